// File: rtl/axi_lite_master_cmd.sv
// rtl/axi_lite_master_cmd.sv - single-outstanding AXI4-Lite master driven by a register request/response stream
module axi_lite_master_cmd #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wr,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_wr,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    output logic [CNT_WIDTH-1:0]    wr_count,
    output logic [CNT_WIDTH-1:0]    rd_count,
    output logic [CNT_WIDTH-1:0]    err_count
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        RSP
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic                    req_ready_q, req_ready_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_wr_q, rsp_wr_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;
    logic [CNT_WIDTH-1:0]    wr_count_q, wr_count_d;
    logic [CNT_WIDTH-1:0]    rd_count_q, rd_count_d;
    logic [CNT_WIDTH-1:0]    err_count_q, err_count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            req_ready_q <= 1'b1;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            wr_count_q  <= '0;
            rd_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            req_ready_q <= req_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            wr_count_q  <= wr_count_d;
            rd_count_q  <= rd_count_d;
            err_count_q <= err_count_d;
        end
    end

    // Every output is the registered image of a *_d value, so no input reaches an output combinationally.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        req_ready_d = req_ready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_wr_d    = rsp_wr_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        wr_count_d  = wr_count_q;
        rd_count_d  = rd_count_q;
        err_count_d = err_count_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d      = base_addr + req_addr;
                    wdata_d     = req_wdata;
                    wstrb_d     = req_wstrb;
                    rsp_wr_d    = req_wr;
                    req_ready_d = 1'b0;
                    if (req_wr) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready) wvalid_d = 1'b0;
                // Both channels finished, whether this cycle or earlier.
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = m_axi_bresp;
                    wr_count_d  = wr_count_q + CNT_WIDTH'(1);
                    if (m_axi_bresp[1]) err_count_d = err_count_q + CNT_WIDTH'(1);
                    state_d     = RSP;
                end
            end
            RD_REQ: begin
                if (arvalid_q && m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_axi_rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = m_axi_rdata;
                    rsp_resp_d  = m_axi_rresp;
                    rd_count_d  = rd_count_q + CNT_WIDTH'(1);
                    if (m_axi_rresp[1]) err_count_d = err_count_q + CNT_WIDTH'(1);
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_wr        = rsp_valid_q ? rsp_wr_q : 1'b0;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign wr_count      = wr_count_q;
    assign rd_count      = rd_count_q;
    assign err_count     = err_count_q;

endmodule

// File: tb/tb_axi_lite_master_cmd.sv
// tb/tb_axi_lite_master_cmd.sv - directed self-checking bench for axi_lite_master_cmd
module tb_axi_lite_master_cmd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] base_addr = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_wr;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [1:0]  m_axi_bresp = '0;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = '0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;
    logic [15:0] wr_count;
    logic [15:0] rd_count;
    logic [15:0] err_count;

    int checks = 0;
    int errors = 0;

    int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [1:0]  rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = '0;

    axi_lite_master_cmd #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .CNT_WIDTH (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .base_addr    (base_addr),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_wstrb    (req_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_wr       (rsp_wr),
        .rsp_rdata    (rsp_rdata),
        .rsp_resp     (rsp_resp),
        .m_axi_awaddr (m_axi_awaddr),
        .m_axi_awprot (m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready),
        .m_axi_wdata  (m_axi_wdata),
        .m_axi_wstrb  (m_axi_wstrb),
        .m_axi_wvalid (m_axi_wvalid),
        .m_axi_wready (m_axi_wready),
        .m_axi_bresp  (m_axi_bresp),
        .m_axi_bvalid (m_axi_bvalid),
        .m_axi_bready (m_axi_bready),
        .m_axi_araddr (m_axi_araddr),
        .m_axi_arprot (m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata  (m_axi_rdata),
        .m_axi_rresp  (m_axi_rresp),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rready (m_axi_rready),
        .wr_count     (wr_count),
        .rd_count     (rd_count),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    // Slave model: ready/valid after a configurable number of cycles of the master's valid/ready.
    always @(negedge clk) begin
        if (!m_axi_awvalid) begin aw_wait = 0; m_axi_awready = 1'b0; end
        else begin m_axi_awready = (aw_wait >= aw_delay); aw_wait++; end
        if (!m_axi_wvalid) begin w_wait = 0; m_axi_wready = 1'b0; end
        else begin m_axi_wready = (w_wait >= w_delay); w_wait++; end
        if (!m_axi_bready) begin b_wait = 0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00; end
        else begin
            m_axi_bvalid = (b_wait >= b_delay);
            m_axi_bresp  = m_axi_bvalid ? bresp_cfg : 2'b00;
            b_wait++;
        end
        if (!m_axi_arvalid) begin ar_wait = 0; m_axi_arready = 1'b0; end
        else begin m_axi_arready = (ar_wait >= ar_delay); ar_wait++; end
        if (!m_axi_rready) begin r_wait = 0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00; end
        else begin
            m_axi_rvalid = (r_wait >= r_delay);
            m_axi_rdata  = m_axi_rvalid ? rdata_cfg : 32'h0;
            m_axi_rresp  = m_axi_rvalid ? rresp_cfg : 2'b00;
            r_wait++;
        end
    end

    task automatic send_req(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = data;
        req_wstrb = strb;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cycles);
        cycles = 0;
        while (!rsp_valid && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic rsp_handshake;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b exp 1", req_ready); end
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid} !== 6'b0) begin
            errors++; $display("FAIL reset_valids got %b exp 000000",
                {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid});
        end
        checks++;
        if ({m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb} !== 100'h0) begin
            errors++; $display("FAIL reset_addr_data got %h %h %h %h exp 0", m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb);
        end
        checks++;
        if ({rsp_wr, rsp_rdata, rsp_resp} !== 35'h0) begin
            errors++; $display("FAIL reset_rsp got wr=%0b rdata=%h resp=%0d exp 0", rsp_wr, rsp_rdata, rsp_resp);
        end
        checks++;
        if ({wr_count, rd_count, err_count} !== 48'h0) begin
            errors++; $display("FAIL reset_counters got %0d %0d %0d exp 0 0 0", wr_count, rd_count, err_count);
        end
        checks++;
        if ({m_axi_awprot, m_axi_arprot} !== 6'b0) begin
            errors++; $display("FAIL reset_prot got %b %b exp 000", m_axi_awprot, m_axi_arprot);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_basic;
        base_addr = 32'h0001_0000;
        send_req(1'b1, 32'h30, 32'hDEAD_BEEF, 4'hF);
        checks++;
        if (m_axi_awaddr !== 32'h0001_0030) begin errors++; $display("FAIL wr_awaddr got %h exp 00010030", m_axi_awaddr); end
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, req_ready} !== 3'b110) begin
            errors++; $display("FAIL wr_n1_valids got aw=%0b w=%0b rr=%0b exp 1 1 0", m_axi_awvalid, m_axi_wvalid, req_ready);
        end
        checks++;
        if ({m_axi_wdata, m_axi_wstrb} !== {32'hDEAD_BEEF, 4'hF}) begin
            errors++; $display("FAIL wr_wdata got %h/%h exp deadbeef/f", m_axi_wdata, m_axi_wstrb);
        end
        @(negedge clk);
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b001) begin
            errors++; $display("FAIL wr_n2_bready got aw=%0b w=%0b b=%0b exp 0 0 1", m_axi_awvalid, m_axi_wvalid, m_axi_bready);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_wr, rsp_resp, rsp_rdata, m_axi_bready} !== {1'b1, 1'b1, 2'b00, 32'h0, 1'b0}) begin
            errors++; $display("FAIL wr_n3_rsp got v=%0b wr=%0b resp=%0d rdata=%h bready=%0b exp 1 1 0 0 0",
                rsp_valid, rsp_wr, rsp_resp, rsp_rdata, m_axi_bready);
        end
        checks++;
        if (wr_count !== 16'd1) begin errors++; $display("FAIL wr_count1 got %0d exp 1", wr_count); end
        rsp_handshake();
        checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            errors++; $display("FAIL wr_rsp_done got v=%0b rr=%0b exp 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_write_wready_early;
        int cycles;
        logic extra;
        aw_delay = 3;
        send_req(1'b1, 32'h34, 32'h0000_1111, 4'h3);
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b110) begin
            errors++; $display("FAIL early_n1 got aw=%0b w=%0b b=%0b exp 1 1 0", m_axi_awvalid, m_axi_wvalid, m_axi_bready);
        end
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b100) begin
                errors++; $display("FAIL early_n%0d got aw=%0b w=%0b b=%0b exp 1 0 0", i, m_axi_awvalid, m_axi_wvalid, m_axi_bready);
            end
        end
        @(negedge clk);
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 3'b001) begin
            errors++; $display("FAIL early_n5 got aw=%0b w=%0b b=%0b exp 0 0 1", m_axi_awvalid, m_axi_wvalid, m_axi_bready);
        end
        wait_rsp(cycles);
        checks++;
        if (cycles !== 1) begin errors++; $display("FAIL early_rsp_latency got %0d exp 1", cycles); end
        checks++;
        if (wr_count !== 16'd2) begin errors++; $display("FAIL early_wr_count got %0d exp 2", wr_count); end
        rsp_handshake();
        extra = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) extra = 1'b1;
        end
        checks++;
        if ({extra, wr_count} !== {1'b0, 16'd2}) begin
            errors++; $display("FAIL early_single_rsp got extra=%0b wr=%0d exp 0 2", extra, wr_count);
        end
        aw_delay = 0;
    endtask

    task automatic test_read_delayed;
        int cycles;
        ar_delay  = 4;
        r_delay   = 2;
        rdata_cfg = 32'h1234_5678;
        send_req(1'b0, 32'h10, 32'h0, 4'h0);
        checks++;
        if ({m_axi_araddr, m_axi_arvalid, m_axi_rready} !== {32'h0001_0010, 1'b1, 1'b0}) begin
            errors++; $display("FAIL rd_n1 got araddr=%h ar=%0b r=%0b exp 00010010 1 0", m_axi_araddr, m_axi_arvalid, m_axi_rready);
        end
        wait_rsp(cycles);
        checks++;
        if (cycles !== 8) begin errors++; $display("FAIL rd_latency got %0d exp 8", cycles); end
        checks++;
        if ({rsp_rdata, rsp_resp, rsp_wr} !== {32'h1234_5678, 2'b00, 1'b0}) begin
            errors++; $display("FAIL rd_rsp got rdata=%h resp=%0d wr=%0b exp 12345678 0 0", rsp_rdata, rsp_resp, rsp_wr);
        end
        checks++;
        if (rd_count !== 16'd1) begin errors++; $display("FAIL rd_count got %0d exp 1", rd_count); end
        rsp_handshake();
        ar_delay = 0;
        r_delay  = 0;
    endtask

    task automatic test_errors;
        int cycles;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rresp_cfg = 2'b10;
        rdata_cfg = 32'hCAFE_0001;
        send_req(1'b0, 32'h20, 32'h0, 4'h0);
        wait_rsp(cycles);
        checks++;
        if ({rsp_valid, rsp_resp, rsp_wr, rsp_rdata} !== {1'b1, 2'b10, 1'b0, 32'hCAFE_0001}) begin
            errors++; $display("FAIL err_rd_rsp got v=%0b resp=%0d wr=%0b rdata=%h exp 1 2 0 cafe0001",
                rsp_valid, rsp_resp, rsp_wr, rsp_rdata);
        end
        rsp_handshake();
        bresp_cfg = 2'b11;
        send_req(1'b1, 32'h24, 32'h5555_AAAA, 4'hF);
        wait_rsp(cycles);
        checks++;
        if ({rsp_valid, rsp_resp, rsp_wr, rsp_rdata} !== {1'b1, 2'b11, 1'b1, 32'h0}) begin
            errors++; $display("FAIL err_wr_rsp got v=%0b resp=%0d wr=%0b rdata=%h exp 1 3 1 0",
                rsp_valid, rsp_resp, rsp_wr, rsp_rdata);
        end
        rsp_handshake();
        checks++;
        if ({wr_count, rd_count, err_count} !== {16'd1, 16'd1, 16'd2}) begin
            errors++; $display("FAIL err_counts got wr=%0d rd=%0d err=%0d exp 1 1 2", wr_count, rd_count, err_count);
        end
        rresp_cfg = 2'b00;
        bresp_cfg = 2'b00;
    endtask

    task automatic test_rsp_backpressure;
        int cycles;
        base_addr = 32'h0001_0000;
        bresp_cfg = 2'b01;
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 32'h50;
        req_wdata = 32'h0000_00A5;
        req_wstrb = 4'h1;
        @(negedge clk);
        // Next request held pending behind the write; base changes after the write was accepted.
        req_wr    = 1'b0;
        req_addr  = 32'h44;
        base_addr = 32'h2000_0000;
        checks++;
        if (m_axi_awaddr !== 32'h0001_0050) begin errors++; $display("FAIL bp_awaddr got %h exp 00010050", m_axi_awaddr); end
        wait_rsp(cycles);
        checks++;
        if (cycles >= 100) begin errors++; $display("FAIL bp_rsp_timeout got %0d exp <100", cycles); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rsp_valid, req_ready, rsp_wr, rsp_resp, rsp_rdata} !== {1'b1, 1'b0, 1'b1, 2'b01, 32'h0}) begin
                errors++; $display("FAIL bp_hold%0d got v=%0b rr=%0b wr=%0b resp=%0d rdata=%h exp 1 0 1 1 0",
                    i, rsp_valid, req_ready, rsp_wr, rsp_resp, rsp_rdata);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, req_ready, m_axi_arvalid} !== 3'b010) begin
            errors++; $display("FAIL bp_after_hs got v=%0b rr=%0b ar=%0b exp 0 1 0", rsp_valid, req_ready, m_axi_arvalid);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({m_axi_arvalid, req_ready, m_axi_araddr} !== {1'b1, 1'b0, 32'h2000_0044}) begin
            errors++; $display("FAIL bp_next_req got ar=%0b rr=%0b araddr=%h exp 1 0 20000044",
                m_axi_arvalid, req_ready, m_axi_araddr);
        end
        wait_rsp(cycles);
        rsp_handshake();
        checks++;
        if ({wr_count, rd_count, err_count} !== {16'd2, 16'd2, 16'd2}) begin
            errors++; $display("FAIL bp_counts got wr=%0d rd=%0d err=%0d exp 2 2 2", wr_count, rd_count, err_count);
        end
        bresp_cfg = 2'b00;
    endtask

    task automatic test_reset_mid_and_wrap;
        int cycles;
        logic seen;
        aw_delay = 20;
        send_req(1'b1, 32'h8, 32'h0BAD_F00D, 4'hF);
        @(negedge clk);
        checks++;
        if ({m_axi_awvalid, m_axi_awready} !== 2'b10) begin
            errors++; $display("FAIL mid_aw_pending got aw=%0b awready=%0b exp 1 0", m_axi_awvalid, m_axi_awready);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid, req_ready} !== 7'b0000001) begin
            errors++; $display("FAIL mid_rst_valids got %b exp 0000001",
                {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid, req_ready});
        end
        checks++;
        if ({wr_count, rd_count, err_count} !== 48'h0) begin
            errors++; $display("FAIL mid_rst_counters got %0d %0d %0d exp 0 0 0", wr_count, rd_count, err_count);
        end
        rst = 1'b0;
        aw_delay = 0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_rsp got %0b exp 0", seen); end
        base_addr = 32'hFFFF_FFF0;
        send_req(1'b1, 32'h20, 32'h7777_0000, 4'hC);
        checks++;
        if ({m_axi_awaddr, m_axi_awvalid} !== {32'h0000_0010, 1'b1}) begin
            errors++; $display("FAIL wrap_awaddr got %h aw=%0b exp 00000010 1", m_axi_awaddr, m_axi_awvalid);
        end
        wait_rsp(cycles);
        checks++;
        if ({cycles, wr_count} !== {32'd2, 16'd1}) begin
            errors++; $display("FAIL wrap_rsp got latency=%0d wr=%0d exp 2 1", cycles, wr_count);
        end
        rsp_handshake();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_basic();
        test_write_wready_early();
        test_read_delayed();
        test_errors();
        test_rsp_backpressure();
        test_reset_mid_and_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
